video_timing_gen: RTL and testbench

//  Parametrised raster timing generator for the HDMI/DVI output path. It produces pixel

---
 rtl/vtg_pkg.sv | 34 +++
 rtl/vtg_axis_counter.sv | 63 ++++++
 rtl/video_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// Shared constants for the raster timing generator: standard mode parameter sets
// and the helper that derives a line/frame total from its four segment lengths.
package vtg_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
  localparam int VTG_640x480_H_ACTIVE = 640;
  localparam int VTG_640x480_H_FP     = 16;
  localparam int VTG_640x480_H_SYNC   = 96;
  localparam int VTG_640x480_H_BP     = 48;
  localparam int VTG_640x480_V_ACTIVE = 480;
  localparam int VTG_640x480_V_FP     = 10;
  localparam int VTG_640x480_V_SYNC   = 2;
  localparam int VTG_640x480_V_BP     = 33;
  localparam int VTG_640x480_HS_POL   = 0;
  localparam int VTG_640x480_VS_POL   = 0;

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs
  localparam int VTG_1280x720_H_ACTIVE = 1280;
  localparam int VTG_1280x720_H_FP     = 110;
  localparam int VTG_1280x720_H_SYNC   = 40;
  localparam int VTG_1280x720_H_BP     = 220;
  localparam int VTG_1280x720_V_ACTIVE = 720;
  localparam int VTG_1280x720_V_FP     = 5;
  localparam int VTG_1280x720_V_SYNC   = 5;
  localparam int VTG_1280x720_V_BP     = 20;
  localparam int VTG_1280x720_HS_POL   = 1;
  localparam int VTG_1280x720_VS_POL   = 1;

  function automatic int vtg_total(input int active, input int fp, input int sync,
                                   input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: a wrapping position counter plus the active-region and sync
// decodes for that axis. Used once for pixels within a line, once for lines.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = 0,
  parameter int CW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int CW1 = CW + 1;
  localparam int TOTAL = vtg_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW:0]   ACT_END    = CW1'(ACTIVE);
  localparam logic [CW:0]   SYNC_BEG   = CW1'(ACTIVE + FP);
  localparam logic [CW:0]   SYNC_END   = CW1'(ACTIVE + FP + SYNC);
  localparam logic          SYNC_LEVEL = (POL != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_w;
  logic          at_last;
  logic          in_sync;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en && step) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Widened by one bit so a sync pulse ending exactly at 2**CW still decodes.
  assign cnt_w   = {1'b0, cnt_q};
  assign in_sync = (cnt_w >= SYNC_BEG) && (cnt_w < SYNC_END);

  assign cnt    = cnt_q;
  assign wrap   = en && step && at_last;
  assign active = (cnt_w < ACT_END);
  assign sync   = in_sync ? SYNC_LEVEL : ~SYNC_LEVEL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: coordinates, data enable, syncs and frame/line strobes,
// all registered together one enabled cycle after the counters. VTG_FRAME_CNT_EN adds frame_cnt.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = VTG_640x480_H_ACTIVE,
  parameter int H_FP     = VTG_640x480_H_FP,
  parameter int H_SYNC   = VTG_640x480_H_SYNC,
  parameter int H_BP     = VTG_640x480_H_BP,
  parameter int V_ACTIVE = VTG_640x480_V_ACTIVE,
  parameter int V_FP     = VTG_640x480_V_FP,
  parameter int V_SYNC   = VTG_640x480_V_SYNC,
  parameter int V_BP     = VTG_640x480_V_BP,
  parameter int HS_POL   = VTG_640x480_HS_POL,
  parameter int VS_POL   = VTG_640x480_VS_POL,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          sof,
  output logic          eol
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW))) begin : g_cw_too_small
      $error("video_timing_gen: CW=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d",
             CW, H_TOTAL, V_TOTAL);
    end
  endgenerate

  localparam logic [CW-1:0] H_EOL   = CW'(H_ACTIVE - 1);
  localparam logic          HS_IDLE = (HS_POL == 0);
  localparam logic          VS_IDLE = (VS_POL == 0);

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;
  logic          h_active, v_active;
  logic          h_sync, v_sync;

  vtg_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .step   (en),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vtg_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .step   (en && h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  // High exactly while the counters sit at (0,0); saves a 2*CW-bit compare.
  logic frame_start_q;

  logic [CW-1:0] sx_q, sx_d;
  logic [CW-1:0] sy_q, sy_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;

  always_comb begin
    sx_d    = h_cnt;
    sy_d    = v_cnt;
    de_d    = h_active && v_active;
    hsync_d = h_sync;
    vsync_d = v_sync;
    sof_d   = frame_start_q;
    eol_d   = (h_cnt == H_EOL) && v_active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q          <= '0;
      sy_q          <= '0;
      de_q          <= 1'b0;
      hsync_q       <= HS_IDLE;
      vsync_q       <= VS_IDLE;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      frame_start_q <= 1'b1;
    end else if (en) begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      frame_start_q <= v_wrap;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign sof   = sof_q;
  assign eol   = eol_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge that raises sof, so frame 1 reads 1 alongside its sof.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (en && frame_start_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a tiny raster instance checked cycle-by-cycle against a
// scoreboard, plus 640x480 and 1280x720 instances checked over their first lines.
module tb_video_timing_gen;
  import vtg_pkg::*;

  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VA = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HPOL = 1, S_VPOL = 0, S_CW = 6;
  localparam int S_HT = 25, S_VT = 17;
  localparam int W = 2 * S_CW + 5;

  logic clk, rst, en;

  logic [S_CW-1:0] s_sx, s_sy;
  logic            s_de, s_hsync, s_vsync, s_sof, s_eol;
  logic [11:0]     d_sx, d_sy;
  logic            d_de, d_hsync, d_vsync, d_sof, d_eol;
  logic [11:0]     h_sx, h_sy;
  logic            h_de, h_hsync, h_vsync, h_sof, h_eol;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]     s_frame_cnt, d_frame_cnt, h_frame_cnt;
`endif

  int total_checks = 0;
  int bad_checks   = 0;

  int mh, mv, mfc;
  logic [W-1:0] exp_q[$];
  logic [15:0]  fc_q[$];
  logic [W-1:0] last_exp;
  logic [15:0]  last_fc;

  video_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(S_HPOL), .VS_POL(S_VPOL), .CW(S_CW)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .sx(s_sx), .sy(s_sy), .de(s_de),
    .hsync(s_hsync), .vsync(s_vsync), .sof(s_sof), .eol(s_eol)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(s_frame_cnt)
`endif
  );

  video_timing_gen u_vga (
    .clk(clk), .rst(rst), .en(en), .sx(d_sx), .sy(d_sy), .de(d_de),
    .hsync(d_hsync), .vsync(d_vsync), .sof(d_sof), .eol(d_eol)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(d_frame_cnt)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(VTG_1280x720_H_ACTIVE), .H_FP(VTG_1280x720_H_FP),
    .H_SYNC(VTG_1280x720_H_SYNC), .H_BP(VTG_1280x720_H_BP),
    .V_ACTIVE(VTG_1280x720_V_ACTIVE), .V_FP(VTG_1280x720_V_FP),
    .V_SYNC(VTG_1280x720_V_SYNC), .V_BP(VTG_1280x720_V_BP),
    .HS_POL(VTG_1280x720_HS_POL), .VS_POL(VTG_1280x720_VS_POL), .CW(12)
  ) u_hd (
    .clk(clk), .rst(rst), .en(en), .sx(h_sx), .sy(h_sy), .de(h_de),
    .hsync(h_hsync), .vsync(h_vsync), .sof(h_sof), .eol(h_eol)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(h_frame_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_out(input int h, input int v);
    logic de_m, hs_m, vs_m, sof_m, eol_m;
    de_m  = (h < S_HA) && (v < S_VA);
    hs_m  = ((h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS)) ? 1'b1 : 1'b0;
    vs_m  = ((v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS)) ? 1'b0 : 1'b1;
    sof_m = (h == 0) && (v == 0);
    eol_m = (h == S_HA - 1) && (v < S_VA);
    return {S_CW'(h), S_CW'(v), de_m, hs_m, vs_m, sof_m, eol_m};
  endfunction

  // Reset state: zero coordinates, strobes low, hsync low (active-high), vsync high.
  function automatic logic [W-1:0] reset_out();
    return {S_CW'(0), S_CW'(0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic do_cycle(input bit en_v, input bit rst_v);
    logic [W-1:0] got, exp;
    logic [15:0]  exp_fc;
    @(negedge clk);
    en  = en_v;
    rst = rst_v;
    if (rst_v) begin
      mh = 0; mv = 0; mfc = 0;
      last_exp = reset_out();
      last_fc  = 16'd0;
    end else if (en_v) begin
      exp_q.push_back(model_out(mh, mv));
      if (mh == 0 && mv == 0) mfc = (mfc + 1) & 16'hFFFF;
      fc_q.push_back(16'(mfc));
      mh = mh + 1;
      if (mh == S_HT) begin
        mh = 0;
        mv = (mv + 1 == S_VT) ? 0 : mv + 1;
      end
    end
    @(posedge clk);
    #1;
    got = {s_sx, s_sy, s_de, s_hsync, s_vsync, s_sof, s_eol};
    exp = last_exp;
    exp_fc = last_fc;
    if (!rst_v && en_v) begin
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      if (fc_q.size() > 0) exp_fc = fc_q.pop_front();
      last_exp = exp;
      last_fc  = exp_fc;
    end
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      if (bad_checks < 40)
        $display("FAIL sb_out t=%0t got sx=%0d sy=%0d flags=%b expected sx=%0d sy=%0d flags=%b",
                 $time, got[W-1 -: S_CW], got[4+S_CW -: S_CW], got[4:0],
                 exp[W-1 -: S_CW], exp[4+S_CW -: S_CW], exp[4:0]);
    end
`ifdef VTG_FRAME_CNT_EN
    total_checks++;
    if (s_frame_cnt !== exp_fc) begin
      bad_checks++;
      if (bad_checks < 40)
        $display("FAIL sb_frame_cnt t=%0t got=%0d expected=%0d", $time, s_frame_cnt, exp_fc);
    end
`else
    exp_fc = exp_fc;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_cycle(0, 1);
    do_cycle(1, 1);
    total_checks++;
    if (d_sx !== 12'd0 || d_sy !== 12'd0 || d_de !== 1'b0 || d_sof !== 1'b0 ||
        d_eol !== 1'b0 || d_hsync !== 1'b1 || d_vsync !== 1'b1) begin
      bad_checks++;
      $display("FAIL reset_vga got sx=%0d sy=%0d de=%b sof=%b eol=%b hs=%b vs=%b expected 0 0 0 0 0 1 1",
               d_sx, d_sy, d_de, d_sof, d_eol, d_hsync, d_vsync);
    end
    total_checks++;
    if (h_sx !== 12'd0 || h_sy !== 12'd0 || h_de !== 1'b0 || h_sof !== 1'b0 ||
        h_eol !== 1'b0 || h_hsync !== 1'b0 || h_vsync !== 1'b0) begin
      bad_checks++;
      $display("FAIL reset_hd got sx=%0d sy=%0d de=%b sof=%b eol=%b hs=%b vs=%b expected 0 0 0 0 0 0 0",
               h_sx, h_sy, h_de, h_sof, h_eol, h_hsync, h_vsync);
    end
  endtask

  task automatic test_full_frames();
    int sof_prev, de_cnt, max_sx, max_sy, n_per;
    sof_prev = -1; de_cnt = 0; max_sx = 0; max_sy = 0; n_per = 0;
    do_cycle(0, 1);
    for (int i = 0; i < 2 * S_HT * S_VT + 5; i++) begin
      do_cycle(1, 0);
      if (s_sof === 1'b1) begin
        if (sof_prev >= 0) begin
          n_per++;
          total_checks++;
          if (i - sof_prev != S_HT * S_VT) begin
            bad_checks++;
            $display("FAIL sof_period got=%0d expected=%0d", i - sof_prev, S_HT * S_VT);
          end
          total_checks++;
          if (de_cnt != S_HA * S_VA) begin
            bad_checks++;
            $display("FAIL de_per_frame got=%0d expected=%0d", de_cnt, S_HA * S_VA);
          end
        end
        sof_prev = i;
        de_cnt = 0;
      end
      if (s_de === 1'b1) de_cnt++;
      if (int'(s_sx) > max_sx) max_sx = int'(s_sx);
      if (int'(s_sy) > max_sy) max_sy = int'(s_sy);
    end
    total_checks++;
    if (n_per != 2 || max_sx != S_HT - 1 || max_sy != S_VT - 1) begin
      bad_checks++;
      $display("FAIL frame_span got periods=%0d max_sx=%0d max_sy=%0d expected 2 %0d %0d",
               n_per, max_sx, max_sy, S_HT - 1, S_VT - 1);
    end
  endtask

  task automatic test_clock_enable();
    int run, runs;
    run = 0; runs = 0;
    for (int k = 0; k < 4 * (S_HT * S_VT + 20); k++) begin
      do_cycle((k % 4) == 0, 0);
      if (s_sof === 1'b1) run++;
      else if (run != 0) begin
        runs++;
        total_checks++;
        if (run != 4) begin
          bad_checks++;
          $display("FAIL sof_hold_len got=%0d expected=4", run);
        end
        run = 0;
      end
    end
    total_checks++;
    if (runs < 1) begin
      bad_checks++;
      $display("FAIL sof_seen_with_en got=%0d expected>=1", runs);
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    guard = 0;
    while (!(mh == 10 && mv == 5) && guard < 2 * S_HT * S_VT) begin
      do_cycle(1, 0);
      guard++;
    end
    total_checks++;
    if (!(mh == 10 && mv == 5)) begin
      bad_checks++;
      $display("FAIL mid_frame_reach got h=%0d v=%0d expected 10 5", mh, mv);
    end
    for (int r = 0; r < 3; r++) begin
      do_cycle(1, 1);
      total_checks++;
      if (s_de !== 1'b0 || s_sx !== '0 || s_sy !== '0) begin
        bad_checks++;
        $display("FAIL mid_reset got sx=%0d sy=%0d de=%b expected 0 0 0", s_sx, s_sy, s_de);
      end
    end
    do_cycle(1, 0);
    total_checks++;
    if (s_sof !== 1'b1 || s_de !== 1'b1 || s_sx !== '0 || s_sy !== '0) begin
      bad_checks++;
      $display("FAIL post_reset_first got sx=%0d sy=%0d sof=%b de=%b expected 0 0 1 1",
               s_sx, s_sy, s_sof, s_de);
    end
  endtask

  task automatic test_mode_lines();
    int dx, dy, hx, hy;
    do_cycle(0, 1);
    for (int i = 0; i < 1700; i++) begin
      do_cycle(1, 0);
      dx = i % 800; dy = i / 800;
      hx = i % 1650; hy = i / 1650;
      total_checks++;
      if (d_sx !== 12'(dx) || d_sy !== 12'(dy) || d_de !== (dx < 640) ||
          d_hsync !== !(dx >= 656 && dx < 752) || d_eol !== (dx == 639) ||
          d_vsync !== 1'b1) begin
        bad_checks++;
        if (bad_checks < 40)
          $display("FAIL vga_line got sx=%0d sy=%0d de=%b hs=%b eol=%b vs=%b expected sx=%0d sy=%0d",
                   d_sx, d_sy, d_de, d_hsync, d_eol, d_vsync, dx, dy);
      end
      total_checks++;
      if (h_sx !== 12'(hx) || h_sy !== 12'(hy) || h_de !== (hx < 1280) ||
          h_hsync !== (hx >= 1390 && hx < 1430) || h_eol !== (hx == 1279) ||
          h_vsync !== 1'b0) begin
        bad_checks++;
        if (bad_checks < 40)
          $display("FAIL hd_line got sx=%0d sy=%0d de=%b hs=%b eol=%b vs=%b expected sx=%0d sy=%0d",
                   h_sx, h_sy, h_de, h_hsync, h_eol, h_vsync, hx, hy);
      end
    end
  endtask

  task automatic test_frame_cnt();
    do_cycle(0, 1);
`ifdef VTG_FRAME_CNT_EN
    begin
      int nsof;
      nsof = 0;
      total_checks++;
      if (s_frame_cnt !== 16'd0) begin
        bad_checks++;
        $display("FAIL frame_cnt_reset got=%0d expected=0", s_frame_cnt);
      end
      for (int i = 0; i < 3 * S_HT * S_VT + 10 && nsof < 3; i++) begin
        do_cycle(1, 0);
        if (s_sof === 1'b1) begin
          nsof++;
          total_checks++;
          if (s_frame_cnt !== 16'(nsof)) begin
            bad_checks++;
            $display("FAIL frame_cnt_at_sof got=%0d expected=%0d", s_frame_cnt, nsof);
          end
        end
      end
      total_checks++;
      if (nsof != 3) begin
        bad_checks++;
        $display("FAIL frame_cnt_sofs got=%0d expected=3", nsof);
      end
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    mh = 0; mv = 0; mfc = 0;
    last_exp = reset_out();
    last_fc  = 16'd0;
    test_reset();
    test_full_frames();
    test_clock_enable();
    test_reset_mid_frame();
    test_mode_lines();
    test_frame_cnt();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
